// File: rtl/ethtx_pkg.sv
// Shared definitions for the ethernet TX path: FSM state encoding, preamble/SFD
// constants and a bytes-to-beats helper.
package ethtx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_DATA = 2'd2,
        ST_GAP  = 2'd3
    } tx_state_e;

    localparam logic [3:0] ETH_PREAMBLE_NIBBLE = 4'h5;
    localparam logic [7:0] ETH_SFD_BYTE        = 8'hD5;

    function automatic int bytes_to_beats(input int bytes, input int dw);
        return (bytes * 8) / dw;
    endfunction

endpackage

// File: rtl/txpreamble.sv
// Ethernet TX preamble inserter with valid/ready backpressure and abort.
// Optional TXPREAMBLE_IFG_EN adds an enforced inter-frame gap (GAP state).
module txpreamble
    import ethtx_pkg::*;
#(
    parameter int DW             = 4,
    parameter int PREAMBLE_BYTES = 7,
    parameter int IFG_BYTES      = 12
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_ce,
    input  logic          i_en,
    input  logic          i_cancel,
    input  logic          i_v,
    input  logic [DW-1:0] i_d,
    output logic          o_ready,
    output logic          o_v,
    output logic [DW-1:0] o_d,
    output logic          o_busy
);

    localparam int PB   = bytes_to_beats(PREAMBLE_BYTES, DW);
    localparam int SB   = bytes_to_beats(1, DW);
    localparam int IFGB = bytes_to_beats(IFG_BYTES, DW);
    localparam int CMAX = (PB + SB > IFGB) ? (PB + SB) : IFGB;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] PRE_LOAD = CW'(PB + SB - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(IFGB - 1);
    localparam logic [DW-1:0] PRE_PAT  = {(DW/4){ETH_PREAMBLE_NIBBLE}};
    // Last SFD beat: 0xD for nibble beats, the whole 0xD5 for byte beats.
    localparam logic [DW-1:0] SFD_LAST = ETH_SFD_BYTE[7 -: DW];

`ifdef TXPREAMBLE_IFG_EN
    localparam tx_state_e END_ST = ST_GAP;
`else
    localparam tx_state_e END_ST = ST_IDLE;
`endif

    tx_state_e     state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          ov_nxt;
    logic [DW-1:0] od_nxt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            o_v   <= 1'b0;
            o_d   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            o_v   <= ov_nxt;
            o_d   <= od_nxt;
        end
    end

    // End of packet and abort both reload the counter; harmless when END_ST is IDLE.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (i_ce) begin
            case (state)
                ST_IDLE: begin
                    if (i_v && !i_cancel) begin
                        if (i_en) begin
                            state_nxt = ST_PRE;
                            cnt_nxt   = PRE_LOAD;
                        end else begin
                            state_nxt = ST_DATA;
                        end
                    end
                end
                ST_PRE: begin
                    if (i_cancel) begin
                        state_nxt = END_ST;
                        cnt_nxt   = GAP_LOAD;
                    end else if (cnt == '0) begin
                        state_nxt = ST_DATA;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (i_cancel || !i_v) begin
                        state_nxt = END_ST;
                        cnt_nxt   = GAP_LOAD;
                    end
                end
                ST_GAP: begin
                    if (cnt == '0) state_nxt = ST_IDLE;
                    else           cnt_nxt   = cnt - 1'b1;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        ov_nxt  = o_v;
        od_nxt  = o_d;
        o_ready = i_ce && (state == ST_DATA) && !i_cancel;
        o_busy  = (state != ST_IDLE);
        if (i_ce) begin
            case (state)
                ST_PRE: begin
                    if (i_cancel) begin
                        ov_nxt = 1'b0;
                    end else begin
                        ov_nxt = 1'b1;
                        od_nxt = (cnt == '0) ? SFD_LAST : PRE_PAT;
                    end
                end
                ST_DATA: begin
                    if (i_cancel) begin
                        ov_nxt = 1'b0;
                    end else begin
                        ov_nxt = i_v;
                        od_nxt = i_d;
                    end
                end
                default: ov_nxt = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_txpreamble.sv
// Directed bench for txpreamble: nibble and byte instances, source model with
// backpressure, cancel, pass-through, gap and mid-packet reset.
module tb_txpreamble;

    localparam int GAPB =
`ifdef TXPREAMBLE_IFG_EN
        24;
`else
        0;
`endif

    logic i_clk = 1'b0;
    always #5 i_clk = ~i_clk;
    logic i_reset;

    logic       ce4, en4, can4, v4, rdy4, ov4, busy4;
    logic [3:0] d4, od4;
    logic       ce8, en8, can8, v8, rdy8, ov8, busy8;
    logic [7:0] d8, od8;

    txpreamble #(.DW(4), .PREAMBLE_BYTES(7), .IFG_BYTES(12)) u_dut4 (
        .i_clk(i_clk), .i_reset(i_reset), .i_ce(ce4), .i_en(en4), .i_cancel(can4),
        .i_v(v4), .i_d(d4), .o_ready(rdy4), .o_v(ov4), .o_d(od4), .o_busy(busy4));

    txpreamble #(.DW(8), .PREAMBLE_BYTES(7), .IFG_BYTES(12)) u_dut8 (
        .i_clk(i_clk), .i_reset(i_reset), .i_ce(ce8), .i_en(en8), .i_cancel(can8),
        .i_v(v8), .i_d(d8), .o_ready(rdy8), .o_v(ov8), .o_d(od8), .o_busy(busy8));

    int n_chk = 0;
    int n_err = 0;

    bit         sv[$];
    logic [7:0] sd[$];
    logic [7:0] cap[$];
    int         capc[$];
    bit         rdyq[$];
    bit         busyq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        {ce4, en4, can4, v4} = 4'b0; d4 = '0;
        {ce8, en8, can8, v8} = 4'b0; d8 = '0;
    endtask

    task automatic pulse_reset();
        idle_inputs();
        i_reset = 1'b1;
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        sv.delete(); sd.delete(); cap.delete(); capc.delete();
        rdyq.delete(); busyq.delete();
    endtask

    task automatic push(input bit v, input logic [7:0] d);
        sv.push_back(v);
        sd.push_back(d);
    endtask

    // Source holds a valid entry until accepted; a bubble entry lasts one ce beat.
    task automatic run(input bit w8, input int cycles, input int cancel_at,
                       input bit en_in, input bit tog_en, input bit ce_tog);
        int sidx = 0;
        bit ce, en, acc, cur_v, ov, busy;
        logic [7:0] cur_d, od;
        logic [8:0] prev = '0;
        for (int c = 0; c < cycles; c++) begin
            ce    = ce_tog ? (c % 2 == 0) : 1'b1;
            en    = (tog_en && c > 0) ? (c % 2 == 1) : en_in;
            cur_v = (sidx < sv.size()) ? sv[sidx] : 1'b0;
            cur_d = (sidx < sv.size()) ? sd[sidx] : 8'h00;
            if (w8) begin
                ce8 = ce; en8 = en; can8 = (c == cancel_at); v8 = cur_v; d8 = cur_d;
            end else begin
                ce4 = ce; en4 = en; can4 = (c == cancel_at); v4 = cur_v; d4 = cur_d[3:0];
            end
            #1;
            acc = w8 ? rdy8 : rdy4;
            @(posedge i_clk); #1;
            if (cur_v ? acc : ce) sidx++;
            if (c == cancel_at) sidx = sv.size();
            ov   = w8 ? ov8 : ov4;
            od   = w8 ? od8 : {4'h0, od4};
            busy = w8 ? busy8 : busy4;
            rdyq.push_back(acc);
            busyq.push_back(busy);
            if (!ce) begin
                chk("hold", {ov, od}, prev);
            end else if (ov) begin
                cap.push_back(od);
                capc.push_back(c);
            end
            prev = {ov, od};
        end
        idle_inputs();
    endtask

    initial begin
        logic [7:0] exp8;
        int sum;
        i_reset = 1'b0;
        idle_inputs();

        // Reset state
        pulse_reset();
        ce4 = 1'b1; ce8 = 1'b1; #1;
        chk("rst_ov4", ov4, 0);   chk("rst_od4", od4, 0);
        chk("rst_busy4", busy4, 0); chk("rst_rdy4", rdy4, 0);
        chk("rst_ov8", ov8, 0);   chk("rst_busy8", busy8, 0);

        // Nibble packet with preamble
        pulse_reset();
        push(1, 8'hA); push(1, 8'hB); push(1, 8'hC); push(1, 8'hD); push(0, 8'h0);
        run(0, 30, -1, 1, 0, 0);
        chk("p4_len", cap.size(), 20);
        if (cap.size() == 20) begin
            for (int i = 0; i < 20; i++) begin
                exp8 = (i < 15) ? 8'h5 : (i == 15) ? 8'hD : 8'(8'hA + i - 16);
                chk($sformatf("p4_d%0d", i), cap[i], exp8);
            end
            chk("p4_first", capc[0], 1);
            chk("p4_last", capc[19], 20);
        end

        // Byte packet with i_ce toggling
        pulse_reset();
        push(1, 8'h12); push(1, 8'h34); push(0, 8'h0);
        run(1, 30, -1, 1, 0, 1);
        chk("p8_len", cap.size(), 10);
        if (cap.size() == 10) begin
            for (int i = 0; i < 10; i++) begin
                exp8 = (i < 7) ? 8'h55 : (i == 7) ? 8'hD5 : (i == 8) ? 8'h12 : 8'h34;
                chk($sformatf("p8_d%0d", i), cap[i], exp8);
            end
            chk("p8_first", capc[0], 2);
            chk("p8_last", capc[9], 20);
        end

        // Pass-through, i_en toggled mid-packet
        pulse_reset();
        push(1, 8'h1); push(1, 8'h2); push(1, 8'h3); push(0, 8'h0);
        run(0, 12, -1, 0, 1, 0);
        chk("pt_len", cap.size(), 3);
        if (cap.size() == 3) begin
            for (int i = 0; i < 3; i++) chk($sformatf("pt_d%0d", i), cap[i], i + 1);
            chk("pt_first", capc[0], 1);
            chk("pt_last", capc[2], 3);
        end

        // Cancel on the 5th preamble beat
        pulse_reset();
        push(1, 8'hA); push(1, 8'hB); push(0, 8'h0);
        run(0, 40, 5, 1, 0, 0);
        chk("can_len", cap.size(), 4);
        if (cap.size() == 4) chk("can_last", capc[3], 4);
        sum = 0;
        for (int c = 5; c < 40; c++) sum += busyq[c];
        chk("can_busy", sum, GAPB);

        // Back-to-back packets: gap enforcement
        pulse_reset();
        push(1, 8'h6); push(0, 8'h0); push(1, 8'h9); push(0, 8'h0);
        run(0, 70, -1, 1, 0, 0);
        chk("b2b_len", cap.size(), 34);
        if (cap.size() == 34) begin
            chk("b2b_d0", cap[16], 8'h6);
            chk("b2b_end0", capc[16], 17);
            chk("b2b_start1", capc[17], 20 + GAPB);
            chk("b2b_d1", cap[33], 8'h9);
            chk("b2b_end1", capc[33], 36 + GAPB);
        end
        sum = 0;
        for (int c = 19; c <= 19 + GAPB; c++) sum += rdyq[c];
        chk("b2b_rdy_gap", sum, 0);

        // Reset in DATA
        pulse_reset();
        push(1, 8'h1); push(1, 8'h2); push(1, 8'h3); push(0, 8'h0);
        run(0, 3, -1, 0, 0, 0);
        chk("mr_ov_pre", ov4, 1);
        ce4 = 1'b1; v4 = 1'b1; d4 = 4'h3;
        i_reset = 1'b1;
        @(posedge i_clk); #1;
        chk("mr_ov", ov4, 0);
        chk("mr_od", od4, 0);
        chk("mr_busy", busy4, 0);
        chk("mr_rdy", rdy4, 0);
        i_reset = 1'b0;
        idle_inputs();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
